// File: rtl/ysyx_22041207_ifu_prefetch_pkg.sv
// Shared types and constants for the prefetching instruction-fetch unit.
//   fetch_state_e : fetch FSM states (REQ, WAIT, DROP, HALT)
//   ifu_entry_t   : one instruction-queue entry {inst, pc, misaligned}
//   ILEN          : instruction width
//   PC_W          : PC width stored in a queue entry (widest supported XLEN)
package ysyx_22041207_ifu_pkg;

  localparam int ILEN = 32;
  localparam int PC_W = 64;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_DROP,
    ST_HALT
  } fetch_state_e;

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [PC_W-1:0] pc;
    logic            misaligned;
  } ifu_entry_t;

endpackage

// File: rtl/ysyx_22041207_ifu_prefetch_if.sv
// Bundle of all IFU-facing signals: imem request/response handshake,
// EX-stage redirect inputs and the decode-side instruction handshake.
//   master : the fetch unit side
//   slave  : the environment side (instruction memory, EX, decode)
interface ysyx_22041207_ifu_prefetch_if #(
  parameter int XLEN  = 64,
  parameter int MEM_W = 64
);
  import ysyx_22041207_ifu_pkg::*;

  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [XLEN-1:0]  imem_req_addr;
  logic             imem_resp_valid;
  logic [MEM_W-1:0] imem_resp_data;

  logic             ex_jal;
  logic             ex_jalr;
  logic             ex_branch_taken;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_imm;
  logic [XLEN-1:0]  ex_r1data;

  logic             inst_valid;
  logic             inst_ready;
  logic [ILEN-1:0]  inst_o;
  logic [XLEN-1:0]  pc_o;
  logic             inst_misaligned_o;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  ex_jal, ex_jalr, ex_branch_taken, ex_pc, ex_imm, ex_r1data,
    output inst_valid, inst_o, pc_o, inst_misaligned_o,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output ex_jal, ex_jalr, ex_branch_taken, ex_pc, ex_imm, ex_r1data,
    input  inst_valid, inst_o, pc_o, inst_misaligned_o,
    output inst_ready
  );

endinterface

// File: rtl/ysyx_22041207_ifu_prefetch_queue.sv
// In-order instruction queue: circular buffer with wrapping pointers and a
// separate occupancy count.
//   clk, rst   : clock, asynchronous active-high reset (control state only)
//   flush      : empty the queue; a same-cycle push lands in slot 0
//   push       : write push_entry (caller guarantees space)
//   pop        : retire head (ignored when empty or flushing)
//   count      : current occupancy
//   head_valid : queue non-empty
//   head       : head entry, all-zero when empty
module ysyx_22041207_ifu_queue
  import ysyx_22041207_ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  ifu_entry_t                 push_entry,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       head_valid,
  output ifu_entry_t                 head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ifu_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wr_idx;
  logic             do_pop;

  assign do_pop     = pop & head_valid & ~flush;
  assign head_valid = (count != '0);
  assign head       = head_valid ? mem[rptr] : '0;
  // A flush restarts the buffer at slot 0, so a simultaneous push goes there.
  assign wr_idx     = flush ? '0 : wptr;

  // storage: data only, no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_idx] <= push_entry;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= push ? PTR_W'(1) : '0;
      count <= push ? CNT_W'(1) : '0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (do_pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_22041207_ifu_prefetch.sv
// Prefetching instruction-fetch unit. Issues one fetch at a time to
// instruction memory, selects the 32-bit word from the returned beat and
// queues it for decode. EX redirects flush the queue, retarget fetch_pc and
// discard any stale in-flight response; a redirect to a target with bit 1
// set queues a single misaligned marker and halts fetching.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ysyx_22041207_ifu_prefetch_if.master (imem, EX, decode)
module ysyx_22041207_ifu_prefetch
  import ysyx_22041207_ifu_pkg::*;
#(
  parameter int          XLEN     = 64,
  parameter int          MEM_W    = 64,
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic                          clk,
  input logic                          rst,
  ysyx_22041207_ifu_prefetch_if.master bus
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WSEL_W = (MEM_W > ILEN) ? $clog2(MEM_W / ILEN) : 1;

  fetch_state_e     state;
  fetch_state_e     state_nx;
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  fetch_pc_nx;
  logic [XLEN-1:0]  inflight_pc;
  logic [XLEN-1:0]  target;
  logic             halt_pending;
  logic             halt_pending_nx;
  logic             req_valid_q;
  logic             req_valid_nx;
  logic             stale_pending;
  logic             redirect;
  logic             misaligned_tgt;
  logic             accept;
  logic             resp_push;
  logic             q_push;
  logic             q_pop;
  ifu_entry_t       push_entry;
  ifu_entry_t       head;
  logic             head_valid;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nx;

  // Pick the 32-bit word addressed by addr out of a naturally aligned beat.
  function automatic logic [ILEN-1:0] select_word(input logic [MEM_W-1:0] beat,
                                                  input logic [XLEN-1:0]  addr);
    logic [WSEL_W-1:0] idx;
    idx = (MEM_W > ILEN) ? addr[WSEL_W+1:2] : '0;
    return beat[int'(idx)*ILEN +: ILEN];
  endfunction

  // redirect decode: jal/branch target wins over jalr
  assign redirect       = bus.ex_jal | bus.ex_branch_taken | bus.ex_jalr;
  assign target         = (bus.ex_jal | bus.ex_branch_taken)
                        ? bus.ex_pc + bus.ex_imm
                        : (bus.ex_r1data + bus.ex_imm) & ~XLEN'(1);
  assign misaligned_tgt = target[1];

  // handshake and queue control
  assign accept      = req_valid_q & bus.imem_req_ready;
  // fetch_pc advanced on acceptance, so the in-flight address is one word back.
  assign inflight_pc = fetch_pc - XLEN'(4);
  assign resp_push   = (state == ST_WAIT) & bus.imem_resp_valid & ~redirect;
  assign q_push      = (redirect & misaligned_tgt) | resp_push;
  assign q_pop       = head_valid & bus.inst_ready & ~redirect;

  always_comb begin
    push_entry = '0;
    if (redirect) begin
      push_entry.inst       = '0;
      push_entry.pc         = PC_W'(target);
      push_entry.misaligned = 1'b1;
    end else begin
      push_entry.inst       = select_word(bus.imem_resp_data, inflight_pc);
      push_entry.pc         = PC_W'(inflight_pc);
      push_entry.misaligned = 1'b0;
    end
  end

  ysyx_22041207_ifu_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (q_push),
    .push_entry (push_entry),
    .pop        (q_pop),
    .count      (count),
    .head_valid (head_valid),
    .head       (head)
  );

  // next-state: fetch FSM, fetch_pc, and registered request valid
  always_comb begin
    state_nx        = state;
    fetch_pc_nx     = fetch_pc;
    halt_pending_nx = halt_pending;
    // Memory still owes us a beat that must be thrown away.
    stale_pending   = accept |
                      (((state == ST_WAIT) | (state == ST_DROP)) & ~bus.imem_resp_valid);
    if (redirect) begin
      fetch_pc_nx = target;
      if (stale_pending) begin
        state_nx        = ST_DROP;
        halt_pending_nx = misaligned_tgt;
      end else begin
        state_nx        = misaligned_tgt ? ST_HALT : ST_REQ;
        halt_pending_nx = 1'b0;
      end
    end else begin
      case (state)
        ST_REQ: begin
          if (accept) begin
            state_nx    = ST_WAIT;
            fetch_pc_nx = fetch_pc + XLEN'(4);
          end
        end
        ST_WAIT: begin
          if (bus.imem_resp_valid) begin
            state_nx = ST_REQ;
          end
        end
        ST_DROP: begin
          if (bus.imem_resp_valid) begin
            state_nx        = halt_pending ? ST_HALT : ST_REQ;
            halt_pending_nx = 1'b0;
          end
        end
        ST_HALT: state_nx = ST_HALT;
        default: state_nx = ST_REQ;
      endcase
    end

    if (redirect) begin
      count_nx = misaligned_tgt ? CNT_W'(1) : '0;
    end else begin
      case ({q_push, q_pop})
        2'b10:   count_nx = count + CNT_W'(1);
        2'b01:   count_nx = count - CNT_W'(1);
        default: count_nx = count;
      endcase
    end
    // Only request when the slot the response will land in is guaranteed free.
    req_valid_nx = (state_nx == ST_REQ) && (count_nx < CNT_W'(DEPTH));
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_REQ;
      fetch_pc     <= XLEN'(RESET_PC);
      halt_pending <= 1'b0;
      req_valid_q  <= 1'b0;
    end else begin
      state        <= state_nx;
      fetch_pc     <= fetch_pc_nx;
      halt_pending <= halt_pending_nx;
      req_valid_q  <= req_valid_nx;
    end
  end

  assign bus.imem_req_valid    = req_valid_q;
  assign bus.imem_req_addr     = fetch_pc;
  assign bus.inst_valid        = head_valid;
  assign bus.inst_o            = head.inst;
  assign bus.pc_o              = XLEN'(head.pc);
  assign bus.inst_misaligned_o = head.misaligned;

endmodule

// File: tb/tb_ysyx_22041207_ifu_prefetch.sv
module tb_ysyx_22041207_ifu_prefetch;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        mis;
  } ent_t;

  logic clk;
  logic rst;

  ysyx_22041207_ifu_prefetch_if #(.XLEN(64), .MEM_W(64)) bus ();

  ysyx_22041207_ifu_prefetch #(
    .XLEN(64), .MEM_W(64), .DEPTH(DEPTH), .RESET_PC(64'h8000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  ent_t        mq[$];
  ent_t        pops[$];
  logic [63:0] m_pc;
  logic [63:0] m_acc_pc;
  bit          m_out;
  bit          m_stale;
  bit          m_halt;
  bit          skip_req;

  // memory model state
  bit          mem_pend;
  int          mem_cnt;
  logic [63:0] mem_addr;
  int          lat_lo;
  int          lat_hi;

  int          total;
  int          bad;
  bit          last_acc;
  logic [63:0] last_acc_addr;

  function automatic logic [31:0] fword(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [63:0] fbeat(input logic [63:0] a);
    logic [63:0] b;
    b = {a[63:3], 3'b000};
    return {fword(b + 64'd4), fword(b)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc    = 64'h8000_0000;
    m_out   = 0;
    m_stale = 0;
    m_halt  = 0;
  endtask

  // One cycle: called just after a negedge. Checks outputs, drives inputs,
  // advances the model to the upcoming posedge, then waits for the next negedge.
  task automatic step(input bit rdy, input bit irdy, input bit jal, input bit jalr,
                      input bit br, input logic [63:0] epc, input logic [63:0] eimm,
                      input logic [63:0] er1);
    logic [63:0] tgt;
    bit redir, acc, rv;
    ent_t e;
    chk("inst_valid", bus.inst_valid, mq.size() != 0);
    if (mq.size() != 0) e = mq[0];
    else e = '{32'd0, 64'd0, 1'b0};
    chk("inst_o", bus.inst_o, e.inst);
    chk("pc_o", bus.pc_o, e.pc);
    chk("inst_misaligned_o", bus.inst_misaligned_o, e.mis);
    if (!skip_req)
      chk("imem_req_valid", bus.imem_req_valid, !m_halt && !m_out && mq.size() < DEPTH);
    skip_req = 0;

    bus.imem_req_ready  = rdy;
    bus.inst_ready      = irdy;
    bus.ex_jal          = jal;
    bus.ex_jalr         = jalr;
    bus.ex_branch_taken = br;
    bus.ex_pc           = epc;
    bus.ex_imm          = eimm;
    bus.ex_r1data       = er1;
    rv = 0;
    if (mem_pend) begin
      if (mem_cnt == 0) begin
        rv = 1;
        mem_pend = 0;
      end else begin
        mem_cnt--;
      end
    end
    bus.imem_resp_valid = rv;
    bus.imem_resp_data  = rv ? fbeat(mem_addr) : {$urandom, $urandom};
    acc = bus.imem_req_valid && rdy;
    if (acc) begin
      mem_pend = 1;
      mem_addr = bus.imem_req_addr;
      mem_cnt  = $urandom_range(lat_hi - 1, lat_lo - 1);
      chk("imem_req_addr", bus.imem_req_addr, m_pc);
    end

    redir = jal | jalr | br;
    tgt   = (jal | br) ? epc + eimm : ((er1 + eimm) & ~64'd1);
    if (irdy && bus.inst_valid && !redir)
      pops.push_back('{bus.inst_o, bus.pc_o, bus.inst_misaligned_o});
    if (redir) begin
      mq.delete();
      if (rv) m_out = 0;
      if (acc) m_out = 1;
      m_stale = m_out;
      m_pc    = tgt;
      m_halt  = tgt[1];
      if (tgt[1]) mq.push_back('{32'd0, tgt, 1'b1});
    end else begin
      if (irdy && mq.size() > 0) void'(mq.pop_front());
      if (acc) begin
        m_acc_pc = m_pc;
        m_pc     = m_pc + 64'd4;
        m_out    = 1;
        m_stale  = 0;
      end
      if (rv && m_out) begin
        if (!m_stale) mq.push_back('{fword(m_acc_pc), m_acc_pc, 1'b0});
        m_out = 0;
      end
    end
    last_acc      = acc;
    last_acc_addr = bus.imem_req_addr;
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy, input bit irdy);
    step(rdy, irdy, 0, 0, 0, 64'd0, 64'd0, 64'd0);
  endtask

  task automatic wait_acc(input string name, input logic [63:0] exp);
    bit got;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      idle(1, 1);
      if (last_acc) got = 1;
    end
    chk({name, "_accepted"}, got, 1);
    chk(name, last_acc_addr, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;
    total = 0; bad = 0; skip_req = 0; mem_pend = 0; mem_cnt = 0; mem_addr = '0;
    lat_lo = 1; lat_hi = 1; last_acc = 0; last_acc_addr = '0;
    rst = 1'b1;
    bus.imem_req_ready = 0; bus.inst_ready = 0; bus.imem_resp_valid = 0;
    bus.imem_resp_data = '0; bus.ex_jal = 0; bus.ex_jalr = 0; bus.ex_branch_taken = 0;
    bus.ex_pc = '0; bus.ex_imm = '0; bus.ex_r1data = '0;
    model_reset();
    repeat (2) @(negedge clk);

    // reset values
    chk("rst_req_valid", bus.imem_req_valid, 0);
    chk("rst_inst_valid", bus.inst_valid, 0);
    chk("rst_inst_o", bus.inst_o, 0);
    chk("rst_pc_o", bus.pc_o, 0);
    chk("rst_misaligned", bus.inst_misaligned_o, 0);
    rst = 1'b0;
    skip_req = 1;

    // sequential fetch, 1-cycle memory
    pops.delete();
    repeat (14) idle(1, 1);
    chk("seq_count", pops.size() >= 3, 1);
    if (pops.size() >= 3) begin
      chk("seq_pc0", pops[0].pc, 64'h8000_0000);
      chk("seq_pc1", pops[1].pc, 64'h8000_0004);
      chk("seq_pc2", pops[2].pc, 64'h8000_0008);
      chk("seq_inst0", pops[0].inst, 32'h9357_9BDF);
      chk("seq_inst1", pops[1].inst, 32'h9357_9BDB);
      chk("seq_inst2", pops[2].inst, 32'h9357_9BD7);
    end

    // decode stall fills the queue, then drains in order
    repeat (30) idle(1, 0);
    chk("stall_model_full", mq.size(), DEPTH);
    chk("stall_req_valid", bus.imem_req_valid, 0);
    chk("stall_inst_valid", bus.inst_valid, 1);
    pops.delete();
    repeat (30) idle(1, 1);
    chk("drain_count", pops.size() >= 6, 1);
    if (pops.size() >= 6)
      for (int i = 0; i < 5; i++) chk("drain_order", pops[i+1].pc, pops[i].pc + 64'd4);

    // jal while a fetch is in flight
    lat_lo = 2; lat_hi = 2;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      idle(1, 1);
      if (last_acc) found = 1;
    end
    chk("jal_setup", found, 1);
    step(1, 1, 1, 0, 0, 64'h8000_0010, 64'h20, 64'd0);
    pops.delete();
    for (int i = 0; i < 30 && pops.size() == 0; i++) idle(1, 1);
    chk("jal_popped", pops.size() > 0, 1);
    if (pops.size() > 0) begin
      chk("jal_pc", pops[0].pc, 64'h8000_0030);
      chk("jal_inst", pops[0].inst, 32'h9357_9BEF);
      chk("jal_mis", pops[0].mis, 0);
    end

    // jalr clears bit 0; jal beats jalr when both fire
    lat_lo = 1; lat_hi = 1;
    step(1, 1, 0, 1, 0, 64'd0, 64'd0, 64'h8000_0101);
    wait_acc("jalr_addr", 64'h8000_0100);
    step(1, 1, 1, 1, 0, 64'h8000_0100, 64'h100, 64'h8000_0400);
    wait_acc("jal_prio_addr", 64'h8000_0200);

    // misaligned branch target halts fetching
    step(1, 1, 0, 0, 1, 64'h8000_0000, 64'h2, 64'd0);
    n = 0;
    repeat (12) begin
      idle(1, 0);
      n += int'(last_acc);
    end
    chk("halt_no_req", n, 0);
    chk("halt_valid", bus.inst_valid, 1);
    chk("halt_mis", bus.inst_misaligned_o, 1);
    chk("halt_pc", bus.pc_o, 64'h8000_0002);
    chk("halt_inst", bus.inst_o, 0);
    step(1, 0, 1, 0, 0, 64'h8000_0100, 64'd0, 64'd0);
    wait_acc("resume_addr", 64'h8000_0100);

    // asynchronous reset mid-WAIT with two entries queued
    lat_lo = 3; lat_hi = 3;
    step(1, 0, 1, 0, 0, 64'h8000_0000, 64'd0, 64'd0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mq.size() == 2 && m_out) found = 1;
      else idle(1, 0);
    end
    chk("areset_setup", found, 1);
    #2 rst = 1'b1;
    #1;
    chk("areset_inst_valid", bus.inst_valid, 0);
    chk("areset_req_valid", bus.imem_req_valid, 0);
    chk("areset_pc_o", bus.pc_o, 0);
    chk("areset_inst_o", bus.inst_o, 0);
    chk("areset_mis", bus.inst_misaligned_o, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    skip_req = 1;
    for (int i = 0; i < 10 && mem_pend; i++) idle(0, 1);
    chk("late_resp_delivered", mem_pend, 0);
    idle(0, 1);
    chk("late_resp_ignored", bus.inst_valid, 0);
    lat_lo = 1; lat_hi = 1;
    wait_acc("post_reset_addr", 64'h8000_0000);

    // randomized traffic
    lat_lo = 1; lat_hi = 3;
    repeat (3000) begin
      bit rdy, irdy;
      rdy  = ($urandom_range(0, 3) != 0);
      irdy = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) < 3) begin
        int t;
        logic [63:0] epc, eimm, er1;
        t    = $urandom_range(0, 3);
        epc  = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 64'd4;
        eimm = 64'($urandom_range(0, 63)) * 64'd2;
        er1  = 64'h8000_0000 + 64'($urandom_range(0, 4095));
        step(rdy, irdy, (t == 0) || (t == 3), (t == 1) || (t == 3), t == 2, epc, eimm, er1);
      end else begin
        idle(rdy, irdy);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
